// File: rtl/ped_crossing_scheduler.sv
// Pedestrian crossing scheduler: latches kerb requests, holds the main-road light at RED,
// then times walk, clearance and cooldown phases. Optional countdown output via PED_COUNTDOWN_EN.
module ped_crossing_scheduler #(
    parameter int WALK_CYCLES     = 32,
    parameter int CLEAR_CYCLES    = 8,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk_main,
    input  logic             rst_main,
    input  logic [1:0]       ped_req,
    input  logic [1:0]       traffic_light,
    output logic             hold_red,
    output logic             walk,
    output logic [1:0]       ped_ack,
    output logic [CNT_W-1:0] walk_remaining
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WALK,
        CLEAR,
        COOLDOWN
    } state_t;

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [1:0]       LIGHT_RED  = 2'b10;

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic [1:0]       pending, pending_nx;
    logic             hold_red_nx, walk_nx;
    logic [1:0]       ped_ack_nx;
    logic [1:0]       req_all;
    logic             red_seen;

    assign req_all  = pending | ped_req;
    assign red_seen = (traffic_light == LIGHT_RED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_main or posedge rst_main) begin
        if (rst_main) begin
            state    <= IDLE;
            timer    <= '0;
            pending  <= '0;
            hold_red <= 1'b0;
            walk     <= 1'b0;
            ped_ack  <= '0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            pending  <= pending_nx;
            hold_red <= hold_red_nx;
            walk     <= walk_nx;
            ped_ack  <= ped_ack_nx;
        end
    end

    // Every phase ends when the timer reads zero, so the timer never wraps.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        pending_nx = pending;
        unique case (state)
            IDLE: begin
                pending_nx = req_all;
                if (req_all != 2'b00) state_nx = HOLD;
            end
            HOLD: begin
                if (red_seen) begin
                    state_nx   = WALK;
                    timer_nx   = WALK_LOAD;
                    pending_nx = 2'b00;
                end else begin
                    pending_nx = req_all;
                end
            end
            WALK: begin
                if (timer == '0) begin
                    state_nx = CLEAR;
                    timer_nx = CLEAR_LOAD;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            CLEAR: begin
                pending_nx = req_all;
                if (timer == '0) begin
                    state_nx = COOLDOWN;
                    timer_nx = COOL_LOAD;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            COOLDOWN: begin
                pending_nx = req_all;
                if (timer == '0) state_nx = IDLE;
                else             timer_nx = timer - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        hold_red_nx = (state_nx == HOLD) || (state_nx == WALK) || (state_nx == CLEAR);
        walk_nx     = (state_nx == WALK);
        ped_ack_nx  = 2'b00;
        if (state == HOLD && state_nx == WALK) ped_ack_nx = req_all;
        else if (state == WALK)                ped_ack_nx = ped_req;
    end

`ifdef PED_COUNTDOWN_EN
    always_ff @(posedge clk_main or posedge rst_main) begin
        if (rst_main) walk_remaining <= '0;
        else          walk_remaining <= (state_nx == WALK) ? timer_nx + 1'b1 : '0;
    end
`else
    assign walk_remaining = '0;
`endif

endmodule

// File: tb/tb_ped_crossing_scheduler.sv
// Self-checking bench for ped_crossing_scheduler: directed scenarios plus random requests,
// compared every cycle against a timestamp-based model of the crossing phases.
module tb_ped_crossing_scheduler;

    localparam int WALK_CYCLES     = 32;
    localparam int CLEAR_CYCLES    = 8;
    localparam int COOLDOWN_CYCLES = 16;
    localparam int CNT_W           = 8;
    localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10, BAD = 2'b11;

    logic             clk_main = 1'b0;
    logic             rst_main;
    logic [1:0]       ped_req;
    logic [1:0]       traffic_light;
    logic             hold_red, walk;
    logic [1:0]       ped_ack;
    logic [CNT_W-1:0] walk_remaining;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_main = ~clk_main;

    ped_crossing_scheduler #(
        .WALK_CYCLES(WALK_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk_main(clk_main), .rst_main(rst_main), .ped_req(ped_req),
        .traffic_light(traffic_light), .hold_red(hold_red), .walk(walk),
        .ped_ack(ped_ack), .walk_remaining(walk_remaining)
    );

    // Reference model: a crossing is described by the cycle its walk started.
    typedef enum {P_IDLE, P_HOLD, P_WALK, P_CLEAR, P_COOL} phase_t;
    int               cyc;
    int               walk_start;
    bit               holding;
    logic [1:0]       pend;
    logic             exp_hold, exp_walk;
    logic [1:0]       exp_ack;
    logic [CNT_W-1:0] exp_rem;

    // Traffic-light environment state
    int hold_run, red_lat, free_cnt;
    bit free_run;
    logic prev_walk;
    string cur_tag;

    function automatic phase_t phase_at(int m);
        int k;
        if (walk_start >= 0) begin
            k = m - walk_start;
            if (k < WALK_CYCLES) return P_WALK;
            if (k < WALK_CYCLES + CLEAR_CYCLES) return P_CLEAR;
            if (k < WALK_CYCLES + CLEAR_CYCLES + COOLDOWN_CYCLES) return P_COOL;
            return P_IDLE;
        end
        return holding ? P_HOLD : P_IDLE;
    endfunction

    task automatic model_reset();
        cyc = 0; walk_start = -1; holding = 1'b0; pend = 2'b00;
        exp_hold = 1'b0; exp_walk = 1'b0; exp_ack = 2'b00; exp_rem = '0;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [1:0] light);
        phase_t p;
        logic [1:0] ack_next;
        ack_next = 2'b00;
        p = phase_at(cyc);
        case (p)
            P_IDLE: begin
                walk_start = -1;
                if ((pend | req) != 2'b00) holding = 1'b1;
                pend = pend | req;
            end
            P_HOLD: begin
                if (light == RED) begin
                    ack_next = pend | req; pend = 2'b00;
                    holding = 1'b0; walk_start = cyc + 1;
                end else pend = pend | req;
            end
            P_WALK:  ack_next = req;
            default: pend = pend | req;
        endcase
        cyc++;
        p = phase_at(cyc);
        exp_hold = (p == P_HOLD) || (p == P_WALK) || (p == P_CLEAR);
        exp_walk = (p == P_WALK);
        exp_ack  = ack_next;
`ifdef PED_COUNTDOWN_EN
        exp_rem = (p == P_WALK) ? CNT_W'(WALK_CYCLES - (cyc - walk_start)) : '0;
`else
        exp_rem = '0;
`endif
    endtask

    task automatic check_outputs();
        vectors += 4;
        assert (hold_red === exp_hold) else begin
            miscompares++;
            $error("FAIL %s hold_red cyc=%0d observed=%b expected=%b", cur_tag, cyc, hold_red, exp_hold);
        end
        assert (walk === exp_walk) else begin
            miscompares++;
            $error("FAIL %s walk cyc=%0d observed=%b expected=%b", cur_tag, cyc, walk, exp_walk);
        end
        assert (ped_ack === exp_ack) else begin
            miscompares++;
            $error("FAIL %s ped_ack cyc=%0d observed=%b expected=%b", cur_tag, cyc, ped_ack, exp_ack);
        end
        assert (walk_remaining === exp_rem) else begin
            miscompares++;
            $error("FAIL %s walk_remaining cyc=%0d observed=%0d expected=%0d", cur_tag, cyc, walk_remaining, exp_rem);
        end
    endtask

    task automatic check_val(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock cycle: light follows hold_red, inputs driven, model advanced, outputs checked.
    task automatic step(input logic [1:0] req);
        if (hold_run >= red_lat)  traffic_light = RED;
        else if (hold_run > 0)    traffic_light = ($urandom_range(0, 3) == 0) ? BAD : YELLOW;
        else if (free_run) begin
            free_cnt = (free_cnt + 1) % 10;
            if (free_cnt < 5)      traffic_light = GREEN;
            else if (free_cnt < 7) traffic_light = ($urandom_range(0, 1) == 0) ? BAD : YELLOW;
            else                   traffic_light = RED;
        end else                  traffic_light = GREEN;
        if (hold_red) hold_run++; else hold_run = 0;
        prev_walk = walk;
        ped_req = req;
        model_step(req, traffic_light);
        @(posedge clk_main); #1;
        check_outputs();
    endtask

    task automatic wait_walk();
        int budget;
        budget = 0;
        while (!walk && budget < 20) begin step(2'b00); budget++; end
        check_val("walk_start_timeout", int'(walk), 1);
    endtask

    initial begin
        int walk_cnt, ack_cnt, ack_val, clear_gap, crossings, walk_seen, ack10_cnt, low_run;
        logic [1:0] req;
        bit sent;
        int level_left;
        logic [1:0] level_val;

        rst_main = 1'b1; ped_req = 2'b00; traffic_light = GREEN;
        hold_run = 0; red_lat = 1; free_run = 1'b0; free_cnt = 0; prev_walk = 1'b0;
        model_reset();
        cur_tag = "reset";
        repeat (2) begin @(posedge clk_main); #1; check_outputs(); end
        rst_main = 1'b0;
        cur_tag = "idle";
        repeat (3) step(2'b00);

        // Single north request, light turns red one cycle after hold_red
        cur_tag = "single";
        walk_cnt = 0; ack_cnt = 0; ack_val = 0; clear_gap = 0;
        step(2'b01);
        check_val("hold_latency", int'(hold_red), 1);
        for (int i = 0; i < 120; i++) begin
            step(2'b00);
            if (walk) walk_cnt++;
            if (ped_ack != 2'b00) begin ack_cnt++; ack_val = int'(ped_ack); end
            if (hold_red && !walk && walk_cnt > 0) clear_gap++;
        end
        check_val("single_walk_len", walk_cnt, WALK_CYCLES);
        check_val("single_ack_count", ack_cnt, 1);
        check_val("single_ack_value", ack_val, 1);
        check_val("single_clear_len", clear_gap, CLEAR_CYCLES);

        // South request in the 10th walk cycle is served by the running crossing
        cur_tag = "walk_req";
        walk_seen = 0; sent = 1'b0; ack10_cnt = 0; crossings = 0;
        step(2'b01);
        for (int i = 0; i < 150; i++) begin
            req = 2'b00;
            if (walk_seen == 10 && !sent) begin req = 2'b10; sent = 1'b1; end
            step(req);
            if (walk) walk_seen++;
            if (walk && !prev_walk) crossings++;
            if (ped_ack == 2'b10) ack10_cnt++;
        end
        check_val("walk_req_ack10", ack10_cnt, 1);
        check_val("walk_req_crossings", crossings, 1);
        check_val("walk_req_final_hold", int'(hold_red), 0);

        // North request in clearance stays pending and causes a second crossing after cooldown
        cur_tag = "clear_req";
        sent = 1'b0; crossings = 0; ack_cnt = 0; low_run = 0;
        step(2'b01);
        for (int i = 0; i < 200; i++) begin
            req = 2'b00;
            if (!walk && prev_walk && !sent) begin req = 2'b01; sent = 1'b1; end
            step(req);
            if (walk && !prev_walk) crossings++;
            if (ped_ack == 2'b01) ack_cnt++;
            if (crossings == 1 && !hold_red) low_run++;
        end
        check_val("clear_req_crossings", crossings, 2);
        check_val("clear_req_acks", ack_cnt, 2);
        check_val("clear_req_cooldown_min", int'(low_run >= COOLDOWN_CYCLES), 1);

        // Simultaneous and staggered requests share one crossing
        cur_tag = "simul";
        step(2'b11);
        wait_walk();
        check_val("simul_ack", int'(ped_ack), 3);
        repeat (70) step(2'b00);
        cur_tag = "stagger";
        step(2'b01);
        step(2'b10);
        wait_walk();
        check_val("stagger_ack", int'(ped_ack), 3);
        repeat (70) step(2'b00);

        // Reset in the middle of a walk aborts everything immediately
        cur_tag = "mid_reset";
        step(2'b10);
        wait_walk();
        repeat (5) step(2'b00);
        rst_main = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (2) begin @(posedge clk_main); #1; check_outputs(); end
        rst_main = 1'b0;
        hold_run = 0; prev_walk = 1'b0;
        cur_tag = "post_reset";
        repeat (10) step(2'b00);

        // Random requests, free-running light with occasional 11 and variable red latency
        cur_tag = "random";
        free_run = 1'b1;
        level_left = 0; level_val = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            int r;
            red_lat = $urandom_range(1, 3);
            r = $urandom_range(0, 99);
            if (level_left > 0) begin
                req = level_val; level_left--;
            end else if (r < 6) begin
                req = 2'($urandom_range(1, 3));
            end else if (r < 8) begin
                level_val = 2'($urandom_range(1, 3));
                level_left = $urandom_range(1, 40);
                req = level_val;
            end else begin
                req = 2'b00;
            end
            step(req);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
